// File: rtl/render_pkg.sv
// Shared definitions for the raster scan renderer: colours, FSM states and
// the signed point-in-rectangle test used by both hit paths.
package render_pkg;

  // Palette used by the renderer; WHITE is kept for sinks that want a
  // default fill colour.
  localparam logic [23:0] WHITE   = 24'hffffff;
  localparam logic [23:0] BKCOLOR = 24'h00ab00;
  localparam logic [23:0] DOODLE  = 24'h00ff00;
  localparam logic [23:0] BLOCK   = 24'hff0000;

  // Width of the signed coordinate space. 32-bit world values minus a
  // 32-bit camera offset need 33 bits; one more bit keeps rx+w and ry+h
  // from overflowing.
  localparam int COORD_W = 34;

  typedef logic signed [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } state_t;

  // Point (px,py) lies in [rx, rx+w) x [ry, ry+h); all operands are signed.
  function automatic logic in_rect(input coord_t px, input coord_t py,
                                   input coord_t rx, input coord_t ry,
                                   input coord_t w,  input coord_t h);
    return (px >= rx) && (px < rx + w) && (py >= ry) && (py < ry + h);
  endfunction

endpackage

// File: rtl/rect_hit.sv
// Combinational point-in-rectangle compare on signed 34-bit coordinates.
module rect_hit
  import render_pkg::*;
(
  input  coord_t px,
  input  coord_t py,
  input  coord_t rx,
  input  coord_t ry,
  input  coord_t w,
  input  coord_t h,
  output logic   hit
);

  // Pure compare, no state.
  always_comb begin
    hit = in_rect(px, py, rx, ry, w, h);
  end

endmodule

// File: rtl/render_scan_sequencer.sv
// Raster-order pixel renderer. For every pixel it walks the block table one
// entry per cycle through a synchronous read port, then emits the resolved
// colour over a valid/ready handshake.
//
// Handshake: a pixel transfers on a rising clk edge where pixel_valid and
// pixel_ready are both high. While pixel_valid is high, pixel_x, pixel_y and
// pixel_color hold steady until the transfer; pixel_valid is low on the
// cycle after a transfer (no back-to-back pixels).
module render_scan_sequencer
  import render_pkg::*;
#(
  parameter int SCREEN_WIDTH  = 400,
  parameter int SCREEN_HEIGHT = 700,
  parameter int BLOCK_WIDTH   = 40,
  parameter int BLOCK_HEIGHT  = 5,
  parameter int NUM_BLOCKS    = 16,
  parameter int DOODLE_SIZE   = 1,
  parameter int IDX_W         = $clog2(NUM_BLOCKS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_start,
  input  logic [31:0]      doodleX,
  input  logic [31:0]      doodleY,
  input  logic [31:0]      minY,
  output logic [IDX_W-1:0] blk_idx,
  input  logic [31:0]      blk_x,
  input  logic [31:0]      blk_y,
  input  logic             blk_active,
  output logic [31:0]      pixel_x,
  output logic [31:0]      pixel_y,
  output logic [23:0]      pixel_color,
  output logic             pixel_valid,
  input  logic             pixel_ready,
  output logic             busy,
  output logic             frame_done,
  output state_t           fsm_state
);

  // Coordinate counter width covers the larger screen dimension.
  localparam int CW = $clog2((SCREEN_WIDTH > SCREEN_HEIGHT) ? SCREEN_WIDTH : SCREEN_HEIGHT);
  // Scan counter runs 0..NUM_BLOCKS: one issue-only cycle plus one
  // evaluate cycle per table entry.
  localparam int SW = $clog2(NUM_BLOCKS + 1);

  localparam logic [CW-1:0]    X_LAST    = CW'(SCREEN_WIDTH - 1);
  localparam logic [CW-1:0]    Y_LAST    = CW'(SCREEN_HEIGHT - 1);
  localparam logic [SW-1:0]    SCAN_LAST = SW'(NUM_BLOCKS);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_BLOCKS - 1);

  localparam coord_t BLK_W = COORD_W'(BLOCK_WIDTH);
  localparam coord_t BLK_H = COORD_W'(BLOCK_HEIGHT);
  localparam coord_t DOO_S = COORD_W'(DOODLE_SIZE);

  state_t         state;
  logic [CW-1:0]  x_cnt;
  logic [CW-1:0]  y_cnt;
  logic [SW-1:0]  scan_cnt;
  logic           hit_flag;

  // Frame snapshot: inputs are frozen at frame accept so the whole frame is
  // rendered from one consistent camera/doodle position.
  logic [31:0]    doodle_x_snap;
  logic [31:0]    doodle_y_snap;
  logic [31:0]    min_y_snap;

  // Signed views of the current pixel and the rectangles under test.
  coord_t px_s;
  coord_t py_s;
  coord_t blk_rx;
  coord_t blk_ry;
  coord_t doo_rx;
  coord_t doo_ry;

  logic   blk_hit;
  logic   doodle_hit;
  logic   blk_eval;

  // Coordinates widened to the signed compare space; screen y of world
  // objects is world y minus the camera offset and may be negative.
  always_comb begin
    px_s   = COORD_W'(x_cnt);
    py_s   = COORD_W'(y_cnt);
    blk_rx = {2'b00, blk_x};
    blk_ry = {2'b00, blk_y} - {2'b00, min_y_snap};
    doo_rx = {2'b00, doodle_x_snap};
    doo_ry = {2'b00, doodle_y_snap} - {2'b00, min_y_snap};
  end

  rect_hit u_block_hit (
    .px  (px_s),
    .py  (py_s),
    .rx  (blk_rx),
    .ry  (blk_ry),
    .w   (BLK_W),
    .h   (BLK_H),
    .hit (blk_hit)
  );

  rect_hit u_doodle_hit (
    .px  (px_s),
    .py  (py_s),
    .rx  (doo_rx),
    .ry  (doo_ry),
    .w   (DOO_S),
    .h   (DOO_S),
    .hit (doodle_hit)
  );

  // Returned table entry counts only from the second scan cycle on, when
  // the read data belongs to an index issued by this pixel's scan.
  always_comb begin
    blk_eval = (scan_cnt != '0) && blk_active && blk_hit;
  end

  // Main sequencer: frame accept, block scan, pixel emit and frame done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      x_cnt         <= '0;
      y_cnt         <= '0;
      scan_cnt      <= '0;
      hit_flag      <= 1'b0;
      blk_idx       <= '0;
      pixel_color   <= '0;
      pixel_valid   <= 1'b0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      doodle_x_snap <= '0;
      doodle_y_snap <= '0;
      min_y_snap    <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_start) begin
            doodle_x_snap <= doodleX;
            doodle_y_snap <= doodleY;
            min_y_snap    <= minY;
            x_cnt         <= '0;
            y_cnt         <= '0;
            scan_cnt      <= '0;
            hit_flag      <= 1'b0;
            blk_idx       <= '0;
            busy          <= 1'b1;
            state         <= SCAN;
          end
        end

        SCAN: begin
          if (blk_eval) begin
            hit_flag <= 1'b1;
          end
          // Issue the next table address while entries remain.
          if (blk_idx != IDX_LAST) begin
            blk_idx <= blk_idx + IDX_W'(1);
          end
          if (scan_cnt == SCAN_LAST) begin
            // Last entry is being evaluated now, so fold it in directly.
            if (doodle_hit) begin
              pixel_color <= DOODLE;
            end else if (hit_flag || blk_eval) begin
              pixel_color <= BLOCK;
            end else begin
              pixel_color <= BKCOLOR;
            end
            pixel_valid <= 1'b1;
            state       <= EMIT;
          end else begin
            scan_cnt <= scan_cnt + SW'(1);
          end
        end

        EMIT: begin
          if (pixel_ready) begin
            pixel_valid <= 1'b0;
            scan_cnt    <= '0;
            hit_flag    <= 1'b0;
            blk_idx     <= '0;
            if (x_cnt == X_LAST) begin
              x_cnt <= '0;
              if (y_cnt == Y_LAST) begin
                y_cnt      <= '0;
                busy       <= 1'b0;
                frame_done <= 1'b1;
                state      <= DONE;
              end else begin
                y_cnt <= y_cnt + CW'(1);
                state <= SCAN;
              end
            end else begin
              x_cnt <= x_cnt + CW'(1);
              state <= SCAN;
            end
          end
        end

        DONE: begin
          // frame_done is high for exactly this cycle; a frame_start seen
          // here is dropped.
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Coordinate counters zero-extended onto the 32-bit pixel bus.
  always_comb begin
    pixel_x   = 32'(x_cnt);
    pixel_y   = 32'(y_cnt);
    fsm_state = state;
  end

endmodule

// File: tb/tb_render_scan_sequencer.sv
// Self-checking bench for render_scan_sequencer on a small 8x4 screen with a
// two-entry block table held in a synchronous-read memory model.
module tb_render_scan_sequencer;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int BW = 3;
  localparam int BH = 2;
  localparam int NB = 2;
  localparam int DS = 1;
  localparam int IW = $clog2(NB);
  localparam int FRAME_LEN = W * H * (NB + 2) + 1;

  localparam logic [23:0] C_BK     = 24'h00ab00;
  localparam logic [23:0] C_DOODLE = 24'h00ff00;
  localparam logic [23:0] C_BLOCK  = 24'hff0000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          frame_start = 1'b0;
  logic [31:0]   doodle_x = '0;
  logic [31:0]   doodle_y = '0;
  logic [31:0]   min_y = '0;
  logic [IW-1:0] blk_idx;
  logic [31:0]   blk_x;
  logic [31:0]   blk_y;
  logic          blk_active;
  logic [31:0]   pixel_x;
  logic [31:0]   pixel_y;
  logic [23:0]   pixel_color;
  logic          pixel_valid;
  logic          pixel_ready = 1'b0;
  logic          busy;
  logic          frame_done;
  render_pkg::state_t fsm_state;

  // Block table contents (world coordinates).
  logic [31:0] mem_x [NB];
  logic [31:0] mem_y [NB];
  logic        mem_act [NB];

  int checks = 0;
  int errors = 0;

  // Expected pixel stream: {x[15:0], y[15:0], colour[23:0]}.
  logic [55:0] exp_q[$];

  render_scan_sequencer #(
    .SCREEN_WIDTH  (W),
    .SCREEN_HEIGHT (H),
    .BLOCK_WIDTH   (BW),
    .BLOCK_HEIGHT  (BH),
    .NUM_BLOCKS    (NB),
    .DOODLE_SIZE   (DS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .doodleX     (doodle_x),
    .doodleY     (doodle_y),
    .minY        (min_y),
    .blk_idx     (blk_idx),
    .blk_x       (blk_x),
    .blk_y       (blk_y),
    .blk_active  (blk_active),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .pixel_color (pixel_color),
    .pixel_valid (pixel_valid),
    .pixel_ready (pixel_ready),
    .busy        (busy),
    .frame_done  (frame_done),
    .fsm_state   (fsm_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Synchronous-read block store: data follows the address by one cycle.
  always @(posedge clk) begin
    blk_x      <= mem_x[blk_idx];
    blk_y      <= mem_y[blk_idx];
    blk_active <= mem_act[blk_idx];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference colour of screen pixel (x,y) from the rendering rules.
  function automatic logic [23:0] model_color(input int x, input int y,
                                              input logic [31:0] dx, input logic [31:0] dy,
                                              input logic [31:0] my);
    longint px = x;
    longint py = y;
    longint off = {32'b0, my};
    longint ldx = {32'b0, dx};
    longint ldy = {32'b0, dy};
    if (px >= ldx && px < ldx + DS && py >= ldy - off && py < ldy - off + DS)
      return C_DOODLE;
    for (int i = 0; i < NB; i++) begin
      longint bx = {32'b0, mem_x[i]};
      longint sy = longint'({32'b0, mem_y[i]}) - off;
      if (mem_act[i] && px >= bx && px < bx + BW && py >= sy && py < sy + BH)
        return C_BLOCK;
    end
    return C_BK;
  endfunction

  task automatic build_expected(input logic [31:0] dx, input logic [31:0] dy, input logic [31:0] my);
    exp_q.delete();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        exp_q.push_back({16'(x), 16'(y), model_color(x, y, dx, dy, my)});
  endtask

  task automatic set_block(input int i, input logic [31:0] x, input logic [31:0] y, input logic act);
    mem_x[i]   = x;
    mem_y[i]   = y;
    mem_act[i] = act;
  endtask

  // Outputs must all read zero (used right after reset).
  task automatic check_zero(input string name);
    check({name, "_px"}, pixel_x, 0);
    check({name, "_py"}, pixel_y, 0);
    check({name, "_color"}, pixel_color, 0);
    check({name, "_valid"}, pixel_valid, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_done"}, frame_done, 0);
    check({name, "_idx"}, blk_idx, 0);
  endtask

  // Runs one frame from IDLE. Called at a negedge; samples at negedges.
  //  rand_ready : random pixel_ready instead of always-ready
  //  stall_idx/stall_len : hold pixel_ready low for stall_len cycles at that pixel
  //  mid_start_at : cycle at which a stray frame_start (and input changes) appear
  //  abort_idx : assert reset while this pixel is being offered
  task automatic run_frame(input string name, input bit rand_ready, input int stall_idx,
                           input int stall_len, input int mid_start_at, input int abort_idx);
    int cycles = 0;
    int busy_cycles = 0;
    int done_cnt = 0;
    int idx = 0;
    int stall_left = stall_len;
    bit finished = 0;
    bit prev_accept = 0;
    logic [55:0] e;
    build_expected(doodle_x, doodle_y, min_y);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    check({name, "_busy_start"}, busy, 1);
    while (!finished && cycles < 4000) begin
      cycles++;
      if (busy) busy_cycles++;
      if (frame_done) begin
        done_cnt++;
        finished = 1;
      end
      if (prev_accept) check({name, "_valid_drop"}, pixel_valid, 0);
      prev_accept = 0;
      if (mid_start_at >= 0) begin
        frame_start = (cycles == mid_start_at);
        if (cycles == mid_start_at) begin
          doodle_x = $urandom_range(0, 7);
          doodle_y = $urandom_range(0, 20);
          min_y    = $urandom_range(0, 20);
        end
      end
      pixel_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (pixel_valid && !finished) begin
        if (exp_q.size() == 0) begin
          check({name, "_extra_pixel"}, 1, 0);
          finished = 1;
        end else begin
          e = exp_q[0];
          if (idx == abort_idx) begin
            check({name, "_abort_px"}, pixel_x, e[55:40]);
            check({name, "_abort_py"}, pixel_y, e[39:24]);
            reset = 1'b1;
            pixel_ready = 1'b0;
            @(negedge clk);
            reset = 1'b0;
            check_zero({name, "_after_reset"});
            for (int k = 0; k < 8; k++) begin
              @(negedge clk);
              check({name, "_reset_idle"}, {busy, frame_done, pixel_valid}, 0);
            end
            return;
          end else if (idx == stall_idx && stall_left > 0) begin
            pixel_ready = 1'b0;
            stall_left--;
            check({name, "_stall_px"}, pixel_x, e[55:40]);
            check({name, "_stall_py"}, pixel_y, e[39:24]);
            check({name, "_stall_color"}, pixel_color, e[23:0]);
          end else if (pixel_ready) begin
            check({name, "_px"}, pixel_x, e[55:40]);
            check({name, "_py"}, pixel_y, e[39:24]);
            check({name, "_color"}, pixel_color, e[23:0]);
            void'(exp_q.pop_front());
            idx++;
            prev_accept = 1;
          end
        end
      end
      if (!finished) @(negedge clk);
    end
    frame_start = 1'b0;
    pixel_ready = 1'b0;
    if (!finished) check({name, "_timeout"}, 0, 1);
    check({name, "_done_count"}, done_cnt, 1);
    check({name, "_pixels_left"}, exp_q.size(), 0);
    check({name, "_busy_at_done"}, busy, 0);
    if (!rand_ready) check({name, "_frame_len"}, busy_cycles + 1, FRAME_LEN + stall_len);
    // No second frame may start or finish after this one.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check({name, "_tail_idle"}, {busy, frame_done, pixel_valid}, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < NB; i++) set_block(i, 32'd0, 32'd1000, 1'b0);

    // Reset
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    check_zero("idle");

    // Empty frame: nothing active, doodle off screen.
    doodle_x = 100; doodle_y = 0; min_y = 0;
    run_frame("empty", 0, -1, 0, -1, -1);

    // Block hit; inactive entry at the same place has no effect.
    doodle_x = 100; doodle_y = 11; min_y = 10;
    set_block(0, 2, 11, 1'b1);
    set_block(1, 2, 11, 1'b0);
    run_frame("block", 0, -1, 0, -1, -1);

    // Doodle wins over block.
    doodle_x = 3; doodle_y = 11; min_y = 10;
    run_frame("doodle", 0, -1, 0, -1, -1);

    // Backpressure at pixel (5,0) for 5 cycles.
    run_frame("stall", 0, 5, 5, -1, -1);

    // Block partly above the screen (screen y = -1).
    doodle_x = 100; doodle_y = 0; min_y = 10;
    set_block(0, 2, 9, 1'b1);
    run_frame("negy", 0, -1, 0, -1, -1);

    // Stray frame_start and input changes mid-frame are ignored.
    doodle_x = 6; doodle_y = 12; min_y = 10;
    set_block(1, 5, 12, 1'b1);
    run_frame("midstart", 0, -1, 0, 40, -1);

    // Reset while pixel (4,2) is offered, then a fresh frame from (0,0).
    doodle_x = 1; doodle_y = 10; min_y = 10;
    run_frame("abort", 0, -1, 0, -1, 2 * W + 4);
    run_frame("restart", 0, -1, 0, -1, -1);

    // Camera offset near the top of the 32-bit range.
    min_y = 32'hFFFF_FFF0;
    doodle_x = 1; doodle_y = 32'hFFFF_FFF3;
    set_block(0, 5, 32'hFFFF_FFF1, 1'b1);
    set_block(1, 0, 32'hFFFF_FFEF, 1'b1);
    run_frame("wide", 0, -1, 0, -1, -1);

    // Randomised scenes with random backpressure.
    for (int r = 0; r < 4; r++) begin
      min_y    = $urandom_range(2, 12);
      doodle_x = $urandom_range(0, 9);
      doodle_y = min_y + $urandom_range(0, 5) - 1;
      for (int i = 0; i < NB; i++)
        set_block(i, $urandom_range(0, 8), min_y + $urandom_range(0, 5) - 2, 1'($urandom_range(0, 1)));
      run_frame("random", 1, -1, 0, -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
